system_sysid_checker: RTL and testbench
=======================================

# system_sysid_checker

Boot-time Avalon-MM master that reads the two words of the system ID peripheral (ID at word 0, build timestamp at word 1) and compares them against the values the software build was compiled for. It sits directly downstream of the sysid slave on the same interconnect. Its `ok` output gates motor-drive enable, so hardware and software images cannot be mismatched silently. It also reports the captured words and a timeout flag for diagnostics.

## Interface
- `EXPECTED_ID`, default 32'd0: value required at sysid word 0.
- `EXPECTED_TIMESTAMP`, default 32'd1393616007: value required at sysid word 1.
- `TIMEOUT_CYCLES`, default 255: maximum waitrequest-high cycles per read; 0 disables the timeout.
- `AUTO_START`, default 1: when 1, a check starts automatically on the first cycle after reset deasserts.
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to (re)run the check.
- `avm_address`  out  1  sysid word select: 0 = ID, 1 = timestamp.
- `avm_read`  out  1  Avalon read strobe.
- `avm_readdata`  in  32  read data, valid in the cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest`  in  1  fabric stall.
- `busy`  out  1  check in progress.
- `done`  out  1  result valid; held until the next start or reset.
- `ok`  out  1  both words matched and no timeout; qualified by `done`.
- `id_match`, `ts_match`  out  1 each  per-word compare results.
- `timeout`  out  1  a read exceeded `TIMEOUT_CYCLES`.
- `read_id`, `read_ts`  out  32 each  captured words.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, FIN.
- IDLE: `start`=1, or the auto-start pulse, moves to RD_ID. All result registers clear on this entry.
- RD_ID: `avm_read`=1, `avm_address`=0.
  - When `avm_waitrequest`=0: capture `read_id`, set `id_match` = (readdata == EXPECTED_ID), go to RD_TS.
- RD_TS: same handshake with `avm_address`=1.
  - On accept: capture `read_ts`, set `ts_match`, go to FIN.
- FIN: `done`=1, `ok` = `id_match` & `ts_match` & !`timeout`.
  - `start` re-enters RD_ID with results cleared. Otherwise stay in FIN.
- Handshake rules:
  - `avm_address` is stable whenever `avm_read`=1.
  - `avm_read` never drops while `avm_waitrequest`=1, except on timeout or reset.
- Timeout:
  - The wait counter clears on every state entry and increments on each cycle with `avm_read`=1 and `avm_waitrequest`=1.
  - When the count equals `TIMEOUT_CYCLES` and waitrequest is still high: drop `avm_read`, set `timeout`=1, go to FIN. The remaining read is skipped and its match flag stays 0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- `start` is ignored in RD_ID and RD_TS. A `start` in IDLE or FIN is honoured.
- Auto-start is a one-shot flag set by reset. It fires once after reset deasserts; a second check needs `start`.
- Compares are full 32-bit equality, unsigned. No masking.

## Timing
- Reset values:
  - State IDLE.
  - `avm_read`, `avm_address`, `busy`, `done`, `ok`, `id_match`, `ts_match`, `timeout` = 0.
  - `read_id`, `read_ts` = 0.
- All outputs are registered; none is a combinational path from an input.
- With waitrequest tied low, and `start` sampled at edge k:
  - `avm_read`=1 with address 0 in cycle k+1.
  - Address 1 in cycle k+2.
  - `done`=1 and `ok` valid from cycle k+3.
  - Total latency is 3 cycles.
- Each waitrequest-high cycle adds one cycle.
- `busy`=1 exactly while the state is RD_ID or RD_TS.
- Reset asserted mid-read: at the next edge `avm_read`=0 and all outputs return to reset values. The in-flight transaction is abandoned.

## Structure
- Shared package `system_sysid_pkg`:
  - State enum (IDLE, RD_ID, RD_TS, FIN).
  - Word offsets SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1.
  - Default expected ID and timestamp constants, which the sysid slave generator also uses.
- No sub-module; the wait counter and FSM are inline in one module.

## Test plan
- `AUTO_START`=1, waitrequest=0, slave returns 0 / 1393616007: `done` at cycle 3 after reset release, `ok`=1, `read_ts`=1393616007.
- Slave returns timestamp 1393616008: `done`=1, `id_match`=1, `ts_match`=0, `ok`=0.
- waitrequest high for 4 cycles on each word: address stays stable while `avm_read` is held, `done` at cycle 11, `ok`=1.
- `TIMEOUT_CYCLES`=8, waitrequest stuck high on word 0: `avm_read` drops after 8 stall cycles, `timeout`=1, `ok`=0, word 1 never read.
- `start` pulsed during RD_TS: ignored. `start` pulsed in FIN: results clear, a new check completes 3 cycles later.
- `reset` asserted during RD_ID stall: the next cycle shows `avm_read`=0 and all outputs 0. After release, auto-start runs a full check.

Source files
------------

// File: rtl/system_sysid_pkg.sv
// Shared definitions for the boot-time system ID checker: FSM states,
// sysid word offsets and the build's default expected ID/timestamp.
package system_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Word offsets inside the sysid slave.
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Values the software build was compiled against; the sysid slave
    // generator consumes the same constants.
    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1393616007;

    // Width of a counter that must reach 'limit' (never narrower than 1 bit).
    function automatic int sysid_cnt_width(input int unsigned limit);
        if (limit < 2) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/system_sysid_checker.sv
// Boot-time Avalon-MM master: reads sysid word 0 (ID) and word 1 (build
// timestamp), compares both with the compiled-in values and raises ok only
// when both match and neither read stalled past the timeout. All outputs are
// registered.
module system_sysid_checker
    import system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts
);

    localparam int              CNT_W      = sysid_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             auto_pend;

    logic launch;
    logic accept;
    logic stall_expired;
    logic id_hit;
    logic ts_hit;

    // A check is launched by an explicit start or by the one-shot post-reset flag.
    assign launch        = start | auto_pend;
    assign accept        = avm_read & ~avm_waitrequest;
    assign stall_expired = TIMEOUT_EN & avm_waitrequest & (wait_cnt == CNT_LIMIT);
    assign id_hit        = (avm_readdata == EXPECTED_ID);
    assign ts_hit        = (avm_readdata == EXPECTED_TIMESTAMP);

    // Control FSM with registered bus strobes, status flags and captured words.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            auto_pend   <= AUTO_START;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            ok          <= 1'b0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout     <= 1'b0;
            read_id     <= '0;
            read_ts     <= '0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    // Start is only honoured here; results clear on every launch.
                    if (launch) begin
                        state       <= RD_ID;
                        auto_pend   <= 1'b0;
                        wait_cnt    <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        ok          <= 1'b0;
                        id_match    <= 1'b0;
                        ts_match    <= 1'b0;
                        timeout     <= 1'b0;
                        read_id     <= '0;
                        read_ts     <= '0;
                    end
                end

                RD_ID, RD_TS: begin
                    if (accept) begin
                        wait_cnt <= '0;
                        if (state == RD_ID) begin
                            read_id     <= avm_readdata;
                            id_match    <= id_hit;
                            avm_address <= SYSID_ADDR_TS;
                            state       <= RD_TS;
                        end else begin
                            read_ts  <= avm_readdata;
                            ts_match <= ts_hit;
                            ok       <= id_match & ts_hit & ~timeout;
                            avm_read <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end
                    end else if (stall_expired) begin
                        // Give up: the pending and any remaining read are skipped.
                        wait_cnt <= '0;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        ok       <= 1'b0;
                        timeout  <= 1'b1;
                        state    <= FIN;
                    end else begin
                        // Address and read stay put while the fabric stalls.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_system_sysid_checker.sv
// Scoreboard bench for system_sysid_checker: a configurable sysid slave
// model with per-word stall lengths, expected results derived from the
// check rules, and a monitor that compares whenever a result appears.
`timescale 1ns/1ps
module tb_system_sysid_checker;

    localparam int          TMO    = 8;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1393616007;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, ok, id_match, ts_match, timeout;
    logic [31:0] read_id, read_ts;

    system_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TMO),
        .AUTO_START         (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .ok              (ok),
        .id_match        (id_match),
        .ts_match        (ts_match),
        .timeout         (timeout),
        .read_id         (read_id),
        .read_ts         (read_ts)
    );

    always #5 clock = ~clock;

    // Edge counter: value seen at a falling edge = index of the last rising edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Slave model: each read of word w stalls stall_w cycles, then returns data.
    int          stall0 = 0, stall1 = 0, wcnt = 0;
    logic [31:0] id_val = EXP_ID, ts_val = EXP_TS;
    int          acc0 = 0, acc1 = 0;

    assign avm_waitrequest = avm_read && (wcnt < (avm_address ? stall1 : stall0));
    assign avm_readdata    = avm_waitrequest ? 32'hA5A5_5A5A : (avm_address ? ts_val : id_val);

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address) acc1 <= acc1 + 1;
            else             acc0 <= acc0 + 1;
        end
    end

    // Scoreboard entries.
    typedef struct {
        int          done_cyc;
        logic        ok, idm, tsm, tmo;
        logic [31:0] rid, rts;
        int          acc0, acc1;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    // Expected outcome of one check launched at rising edge k.
    function automatic exp_t model_run(input int k, input logic [31:0] idv, input logic [31:0] tsv,
                                       input int s0, input int s1, input int b0, input int b1);
        exp_t r;
        bit id_to, ts_to;
        id_to = (s0 > TMO);
        ts_to = !id_to && (s1 > TMO);
        r.tmo = id_to || ts_to;
        r.rid = id_to ? 32'd0 : idv;
        r.idm = !id_to && (idv == EXP_ID);
        r.rts = r.tmo ? 32'd0 : tsv;
        r.tsm = !r.tmo && (tsv == EXP_TS);
        r.ok  = r.idm && r.tsm && !r.tmo;
        if (id_to)      r.done_cyc = k + 1 + TMO;
        else if (ts_to) r.done_cyc = k + 2 + s0 + TMO;
        else            r.done_cyc = k + 2 + s0 + s1;
        r.acc0 = b0 + (id_to ? 0 : 1);
        r.acc1 = b1 + (r.tmo ? 0 : 1);
        return r;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Input history as seen by the DUT at each rising edge.
    logic rst_q = 1'b0, start_q = 1'b0, busy_q = 1'b0;
    always @(posedge clock) begin
        rst_q   <= reset;
        start_q <= start;
        busy_q  <= busy;
    end

    // Monitor: result checks on each new done, plus per-cycle protocol checks.
    logic done_prev = 1'b0, prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0;
    always @(negedge clock) begin
        chk("busy_eq_read", busy, avm_read);
        if (rst_q) begin
            chk("rst_read", avm_read, 0);     chk("rst_addr", avm_address, 0);
            chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
            chk("rst_ok", ok, 0);             chk("rst_idm", id_match, 0);
            chk("rst_tsm", ts_match, 0);      chk("rst_tmo", timeout, 0);
            chk("rst_read_id", read_id, 0);   chk("rst_read_ts", read_ts, 0);
        end else begin
            if (start_q && !busy_q) begin
                chk("launch_busy", busy, 1);      chk("launch_read", avm_read, 1);
                chk("launch_addr", avm_address, 0); chk("launch_done", done, 0);
                chk("launch_ok", ok, 0);          chk("launch_tmo", timeout, 0);
                chk("launch_idm", id_match, 0);   chk("launch_tsm", ts_match, 0);
                chk("launch_read_id", read_id, 0); chk("launch_read_ts", read_ts, 0);
            end
            if (prev_read && prev_wait && !timeout) begin
                chk("hold_read", avm_read, 1);
                chk("hold_addr", avm_address, prev_addr);
            end
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("ok", ok, e.ok);
                    chk("id_match", id_match, e.idm);
                    chk("ts_match", ts_match, e.tsm);
                    chk("timeout", timeout, e.tmo);
                    chk("read_id", read_id, e.rid);
                    chk("read_ts", read_ts, e.rts);
                    chk("id_reads", acc0, e.acc0);
                    chk("ts_reads", acc1, e.acc1);
                end
            end
        end
        done_prev = done;
        prev_read = avm_read;
        prev_wait = avm_waitrequest;
        prev_addr = avm_address;
    end

    // Stimulus helpers (called at a falling edge).
    task automatic set_slave(input logic [31:0] idv, input logic [31:0] tsv, input int s0, input int s1);
        id_val = idv; ts_val = tsv; stall0 = s0; stall1 = s1;
    endtask

    task automatic launch(input logic [31:0] idv, input logic [31:0] tsv, input int s0, input int s1);
        set_slave(idv, tsv, s0, s1);
        sb_q.push_back(model_run(cyc + 1, idv, tsv, s0, s1, acc0, acc1));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0) begin
            @(negedge clock);
            n++;
            if (n > budget) begin
                $display("FAIL wait_done: no result after %0d cycles, required one", budget);
                $fatal(1, "bench stopped");
            end
        end
    endtask

    task automatic run_check(input logic [31:0] idv, input logic [31:0] tsv, input int s0, input int s1);
        launch(idv, tsv, s0, s1);
        wait_idle(60);
    endtask

    task automatic release_reset(input logic [31:0] idv, input logic [31:0] tsv, input int s0, input int s1);
        set_slave(idv, tsv, s0, s1);
        sb_q.push_back(model_run(cyc + 1, idv, tsv, s0, s1, acc0, acc1));
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ridv, rtsv;
        int n;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);

        // Auto-start after reset, clean slave.
        release_reset(EXP_ID, EXP_TS, 0, 0);
        wait_idle(60);

        // Timestamp off by one, then ID wrong.
        run_check(EXP_ID, EXP_TS + 32'd1, 0, 0);
        run_check(32'd1, EXP_TS, 0, 0);

        // Four stall cycles on each word.
        run_check(EXP_ID, EXP_TS, 4, 4);

        // Stuck on word 0, then stuck on word 1; boundary at exactly TMO stalls.
        run_check(EXP_ID, EXP_TS, 100, 0);
        run_check(EXP_ID, EXP_TS, 2, 100);
        run_check(EXP_ID, EXP_TS, TMO, TMO);
        run_check(EXP_ID, EXP_TS, TMO + 1, 0);

        // Start pulsed while reading the timestamp is ignored.
        launch(EXP_ID, EXP_TS, 0, 3);
        n = 0;
        while (!(avm_read && avm_address)) begin
            @(negedge clock);
            n++;
            if (n > 20) begin
                $display("FAIL reach_rd_ts: never saw address 1 read, required within 20 cycles");
                $fatal(1, "bench stopped");
            end
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle(60);

        // Start in FIN reruns cleanly.
        run_check(EXP_ID, EXP_TS, 0, 0);

        // Reset during a word-0 stall, then auto-start again.
        launch(EXP_ID, EXP_TS, 100, 0);
        repeat (3) @(negedge clock);
        sb_q.delete();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        release_reset(EXP_ID, EXP_TS, 0, 0);
        wait_idle(60);

        // Randomized checks.
        for (int i = 0; i < 14; i++) begin
            ridv = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
            rtsv = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
            run_check(ridv, rtsv, $urandom_range(0, 11), $urandom_range(0, 11));
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "bench stopped");
    end

endmodule
